// File: rtl/mul_seq.sv
// mul_seq: iterative signed fixed-point multiplier, radix-2 shift-add.
// One partial product per clock. Operands and result are Q(WIDTH-FBITS).FBITS,
// and the result is rounded half-to-even.
// The start/busy/done/valid handshake matches the team's iterative divider.
// Optional feature macro: MUL_SAT_EN.
//   When defined, an overflowing result saturates to the symmetric max/min,
//   with valid=1 and ovf=1.
//   When undefined, an overflow leaves val unchanged and sets valid=0.
module mul_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             ovf,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] val
);

  localparam int unsigned WIDTHU = WIDTH - 1;
  localparam int unsigned PW     = 2 * WIDTHU;
  localparam int unsigned CW     = (WIDTHU > 1) ? $clog2(WIDTHU) : 1;
  localparam int unsigned GI     = (FBITS > 0) ? FBITS - 1 : 0;

  localparam logic [WIDTH-1:0] SMALLEST    = {1'b1, {WIDTHU{1'b0}}};
  localparam logic [PW-1:0]    STICKY_MASK = (FBITS > 1) ? ((PW'(1) << (FBITS - 1)) - PW'(1)) : '0;
`ifdef MUL_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {WIDTHU{1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(~SAT_POS + WIDTH'(1));
`endif

  typedef enum logic [2:0] {IDLE, INIT, CALC, ROUND, SIGN} state_t;

  state_t            state;
  logic [PW-1:0]     mcand;     // multiplicand, shifted left once per iteration
  logic [WIDTHU-1:0] mplier;    // multiplier, shifted right once per iteration
  logic [PW-1:0]     p;
  logic [CW-1:0]     cnt;
  logic              sig_diff;
  logic [WIDTHU-1:0] r;

  logic [WIDTHU-1:0] a_mag, b_mag;
  logic [PW:0]       rsh, rounded;
  logic              guard, sticky, inc;

  // Operand magnitudes. SMALLEST never reaches this path, so WIDTHU bits suffice.
  always_comb begin
    a_mag = a[WIDTHU-1:0];
    b_mag = b[WIDTHU-1:0];
    if (a[WIDTH-1]) a_mag = WIDTHU'(~a + WIDTH'(1));
    if (b[WIDTH-1]) b_mag = WIDTHU'(~b + WIDTH'(1));
  end

  // Round-half-even of the accumulator down to FBITS fractional bits.
  always_comb begin
    rsh     = (PW+1)'(p >> FBITS);
    guard   = (FBITS > 0) ? p[GI] : 1'b0;
    sticky  = |(p & STICKY_MASK);
    inc     = (FBITS > 0) && guard && (rsh[0] || sticky);
    rounded = rsh + (PW+1)'(inc);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      val      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      p        <= '0;
      cnt      <= '0;
      sig_diff <= 1'b0;
      r        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if ((a == SMALLEST) || (b == SMALLEST)) begin
              // The magnitude of SMALLEST is not representable, so finish immediately.
              done <= 1'b1;
              ovf  <= 1'b1;
              busy <= 1'b0;
`ifdef MUL_SAT_EN
              val   <= (a[WIDTH-1] ^ b[WIDTH-1]) ? SAT_NEG : SAT_POS;
              valid <= 1'b1;
`else
              valid <= 1'b0;
`endif
            end else begin
              mcand    <= PW'(a_mag);
              mplier   <= b_mag;
              sig_diff <= a[WIDTH-1] ^ b[WIDTH-1];
              valid    <= 1'b0;
              ovf      <= 1'b0;
              state    <= INIT;
            end
          end
        end
        INIT: begin
          // busy rises here so that it spans exactly WIDTH+1 cycles before done.
          p     <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          if (mplier[0]) p <= p + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTHU - 1)) state <= ROUND;
        end
        ROUND: begin
          r     <= rounded[WIDTHU-1:0];
          ovf   <= |rounded[PW:WIDTHU];
          state <= SIGN;
        end
        SIGN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (ovf) begin
`ifdef MUL_SAT_EN
            val   <= sig_diff ? SAT_NEG : SAT_POS;
            valid <= 1'b1;
`else
            valid <= 1'b0;
`endif
          end else begin
            // A zero product is always +0, whatever the operand signs.
            val   <= (sig_diff && (r != '0)) ? (~{1'b0, r} + WIDTH'(1)) : {1'b0, r};
            valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: self-checking bench for mul_seq (WIDTH=32, FBITS=8).
// The reference is plain 64-bit integer arithmetic with round-half-even.
// Honours MUL_SAT_EN the same way as the design.
module tb_mul_seq;

  localparam logic [31:0] SMALLEST = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] a, b, val;
  logic        busy, done, valid, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic        chk_en = 1'b0;
  logic        ovf_chk;
  logic [31:0] exp_val;
  logic        exp_valid, exp_busy, exp_done, exp_ovf;

  mul_seq #(.WIDTH(32), .FBITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .valid(valid), .ovf(ovf), .a(a), .b(b), .val(val)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact signed product, then magnitude rounding, then sign.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [31:0] hold,
                       output logic [31:0] v, output logic vld, output logic ov,
                       output logic early);
    longint pa, pb, prod, mag, q, rem;
    logic neg, over;
    neg   = ma[31] ^ mb[31];
    early = (ma == SMALLEST) || (mb == SMALLEST);
    over  = early;
    q     = 0;
    if (!early) begin
      pa   = longint'($signed(ma));
      pb   = longint'($signed(mb));
      prod = pa * pb;
      mag  = (prod < 0) ? -prod : prod;
      q    = mag / 256;
      rem  = mag % 256;
      if (rem > 128 || (rem == 128 && (q % 2) == 1)) q = q + 1;
      over = (q >= 64'sd2147483648);
    end
    if (over) begin
      ov = 1'b1;
`ifdef MUL_SAT_EN
      v   = neg ? 32'h8000_0001 : 32'h7FFF_FFFF;
      vld = 1'b1;
`else
      v   = hold;
      vld = 1'b0;
`endif
    end else begin
      ov  = 1'b0;
      vld = 1'b1;
      v   = (neg && q != 0) ? 32'(-q) : 32'(q);
    end
  endtask

  // Per-cycle compare of the DUT outputs against the expected timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("val", val, exp_val);
      check("valid", 32'(valid), 32'(exp_valid));
      if (ovf_chk) check("ovf", 32'(ovf), 32'(exp_ovf));
    end
  end

  // One operation. Optionally pulses start again before the edge at offset
  // interfere_at, or asserts rst at the edge at offset reset_at.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tv,
                        input int interfere_at, input int reset_at);
    logic [31:0] ev;
    logic evld, eovf, early, aborted;
    model(ta, tv, exp_val, ev, evld, eovf, early);
    aborted = 1'b0;
    @(negedge clk);
    a = ta; b = tv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    if (early) begin
      exp_done = 1'b1; exp_busy = 1'b0; exp_val = ev; exp_valid = evld;
      exp_ovf = 1'b1; ovf_chk = 1'b1;
    end else begin
      exp_done = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0; ovf_chk = 1'b0;
      for (int t = 1; t <= 34; t++) begin
        if (t == interfere_at) begin start = 1'b1; a = 32'h100; b = 32'h100; end
        if (t == reset_at) rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (rst) begin
          rst = 1'b0;
          exp_busy = 1'b0; exp_done = 1'b0; exp_val = '0; exp_valid = 1'b0;
          exp_ovf = 1'b0; ovf_chk = 1'b1;
          aborted = 1'b1;
          break;
        end
        exp_busy = (t <= 33);
        exp_done = (t == 34);
        if (t == 34) begin
          exp_val = ev; exp_valid = evld; exp_ovf = eovf; ovf_chk = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    exp_done = 1'b0;
    if (!aborted) ovf_chk = 1'b0;
    @(posedge clk); #1;
    ovf_chk = 1'b0;
  endtask

  initial begin
    logic [31:0] v, ta, tv;
    logic vld, ov, early;
    int kind;

    // Pin the model against hand-computed results.
    model(32'h0000_0300, 32'h0000_0280, 32'h1234, v, vld, ov, early);
    check("model_3x2.5", v, 32'h0000_0780);
    model(32'hFFFF_FE80, 32'h0000_0200, 32'h1234, v, vld, ov, early);
    check("model_neg", v, 32'hFFFF_FD00);
    model(32'hFFFF_FF00, 32'h0, 32'h1234, v, vld, ov, early);
    check("model_negzero", v, 32'h0);
    model(32'h1, 32'h80, 32'h1234, v, vld, ov, early);
    check("model_tie_even", v, 32'h0);
    model(32'h3, 32'h80, 32'h1234, v, vld, ov, early);
    check("model_tie_odd", v, 32'h2);
    model(32'h3, 32'h81, 32'h1234, v, vld, ov, early);
    check("model_above_half", v, 32'h2);
    model(32'h0100_0000, 32'h0100_0000, 32'h1234, v, vld, ov, early);
    check("model_ovf_flag", 32'(ov), 32'h1);
`ifdef MUL_SAT_EN
    check("model_ovf_sat", v, 32'h7FFF_FFFF);
`else
    check("model_ovf_hold", v, 32'h1234);
`endif
    model(SMALLEST, 32'h100, 32'h1234, v, vld, ov, early);
    check("model_smallest", 32'(early), 32'h1);

    // Reset state.
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_val = '0; exp_valid = 1'b0;
    exp_ovf = 1'b0; ovf_chk = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ovf_chk = 1'b0;

    // Directed vectors.
    run_op(32'h0000_0300, 32'h0000_0280, 0, 0);
    run_op(32'hFFFF_FE80, 32'h0000_0200, 0, 0);
    run_op(32'hFFFF_FF00, 32'h0000_0000, 0, 0);
    run_op(32'h0000_0001, 32'h0000_0080, 0, 0);
    run_op(32'h0000_0003, 32'h0000_0080, 0, 0);
    run_op(32'h0000_0003, 32'h0000_0081, 0, 0);
    run_op(32'h0100_0000, 32'h0100_0000, 0, 0);
    run_op(32'hFF00_0000, 32'h0100_0000, 0, 0);
    run_op(SMALLEST, 32'h0000_0100, 0, 0);
    run_op(32'hFFFF_FF00, SMALLEST, 0, 0);

    // Reset mid-operation, then a start pulse while busy.
    run_op(32'h0000_0300, 32'h0000_0280, 0, 10);
    run_op(32'h0000_0300, 32'h0000_0280, 5, 0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      ta = $urandom; tv = $urandom;
      case (kind)
        1: begin ta = 32'($signed(16'($urandom))); tv = 32'($signed(16'($urandom))); end
        2: begin ta = 32'($signed(24'($urandom))); tv = 32'($signed(20'($urandom))); end
        3: if ($urandom_range(0, 1) == 1) ta = SMALLEST; else tv = SMALLEST;
        4: begin ta = 32'($signed(8'($urandom))); tv = 32'($urandom_range(0, 3)) << 7; end
        default: ;
      endcase
      run_op(ta, tv, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : 0, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
